// File: rtl/rom_arbiter.sv
// rom_arbiter: shares a single-port synchronous-read ROM between two readers.
// Port 0 is the instruction fetch; port 1 is a secondary table/DMA reader.
module rom_arbiter #(
    parameter int AddrWidth  = 8,
    parameter int DataWidth  = 8,
    parameter int MaxWait    = 4,
    parameter int RoundRobin = 0
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic                 REQ0,
    input  logic [AddrWidth-1:0] ADDR0,
    output logic                 ACK0,
    output logic                 VALID0,
    output logic [DataWidth-1:0] DATA0,
    input  logic                 REQ1,
    input  logic [AddrWidth-1:0] ADDR1,
    output logic                 ACK1,
    output logic                 VALID1,
    output logic [DataWidth-1:0] DATA1,
    output logic [AddrWidth-1:0] ROM_ADDR,
    input  logic [DataWidth-1:0] ROM_DATA
);

    localparam logic [3:0] WaitMax = 4'(MaxWait);
    localparam bit         IsRr    = (RoundRobin != 0);

    logic                 last_grant;
    logic [3:0]           wait_cnt;
    logic [3:0]           wait_nxt;
    logic [AddrWidth-1:0] last_addr;
    logic                 own0;
    logic                 own1;
    logic                 grant0;
    logic                 grant1;
    logic                 pick1;

    // Tie-break choice when both ports request in the same cycle.
    always_comb begin
        pick1 = 1'b0;
        if (IsRr) begin
            pick1 = ~last_grant;
        end else begin
            pick1 = (wait_cnt == WaitMax);
        end
    end

    // Grant decision; nothing is accepted while reset is asserted.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (RESET_N) begin
            unique case ({REQ1, REQ0})
                2'b01: grant0 = 1'b1;
                2'b10: grant1 = 1'b1;
                2'b11: begin
                    grant0 = ~pick1;
                    grant1 = pick1;
                end
                default: begin
                    grant0 = 1'b0;
                    grant1 = 1'b0;
                end
            endcase
        end
    end

    // Address mux; an idle cycle re-reads the last address harmlessly.
    always_comb begin
        ROM_ADDR = last_addr;
        if (grant0) begin
            ROM_ADDR = ADDR0;
        end else if (grant1) begin
            ROM_ADDR = ADDR1;
        end
    end

    // Starvation counter for port 1 in fixed-priority mode.
    always_comb begin
        wait_nxt = 4'd0;
        if (!IsRr && REQ1 && !grant1) begin
            if (wait_cnt < WaitMax) begin
                wait_nxt = wait_cnt + 4'd1;
            end else begin
                wait_nxt = WaitMax;
            end
        end
    end

    // Arbiter state and the owner tag of the read now in the ROM.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            last_addr  <= '0;
            last_grant <= 1'b1;
            wait_cnt   <= 4'd0;
            own0       <= 1'b0;
            own1       <= 1'b0;
        end else begin
            last_addr <= ROM_ADDR;
            wait_cnt  <= wait_nxt;
            own0      <= grant0;
            own1      <= grant1;
            if (grant0 || grant1) begin
                last_grant <= grant1;
            end
        end
    end

    // A read in flight when reset arrives is dropped at once.
    always_comb begin
        ACK0   = grant0;
        ACK1   = grant1;
        VALID0 = own0 & RESET_N;
        VALID1 = own1 & RESET_N;
        DATA0  = VALID0 ? ROM_DATA : '0;
        DATA1  = VALID1 ? ROM_DATA : '0;
    end

endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: drives a fixed-priority and a round-robin arbiter in parallel
// and compares both against a cycle-level reference model.
module tb_rom_arbiter;

    localparam int MAX_WAIT = 4;

    logic       clk;
    logic       rst_n;
    logic       req0;
    logic       req1;
    logic [7:0] addr0;
    logic [7:0] addr1;

    logic       f_ack0, f_ack1, f_v0, f_v1;
    logic [7:0] f_d0, f_d1, f_ra, f_rd;
    logic       r_ack0, r_ack1, r_v0, r_v1;
    logic [7:0] r_d0, r_d1, r_ra, r_rd;

    logic [7:0] rom_mem [256];

    logic [27:0] obs_f;
    logic [27:0] obs_r;
    logic [27:0] ef;
    logic [27:0] er;

    int checks;
    int errors;
    int cyc;

    int         m_wait  [2];
    int         m_lastg [2];
    int         m_own   [2];
    logic [7:0] m_laddr [2];
    logic [7:0] m_oaddr [2];

    rom_arbiter #(
        .AddrWidth(8), .DataWidth(8), .MaxWait(MAX_WAIT), .RoundRobin(0)
    ) u_fix (
        .CLK(clk), .RESET_N(rst_n),
        .REQ0(req0), .ADDR0(addr0), .ACK0(f_ack0), .VALID0(f_v0), .DATA0(f_d0),
        .REQ1(req1), .ADDR1(addr1), .ACK1(f_ack1), .VALID1(f_v1), .DATA1(f_d1),
        .ROM_ADDR(f_ra), .ROM_DATA(f_rd)
    );

    rom_arbiter #(
        .AddrWidth(8), .DataWidth(8), .MaxWait(MAX_WAIT), .RoundRobin(1)
    ) u_rr (
        .CLK(clk), .RESET_N(rst_n),
        .REQ0(req0), .ADDR0(addr0), .ACK0(r_ack0), .VALID0(r_v0), .DATA0(r_d0),
        .REQ1(req1), .ADDR1(addr1), .ACK1(r_ack1), .VALID1(r_v1), .DATA1(r_d1),
        .ROM_ADDR(r_ra), .ROM_DATA(r_rd)
    );

    assign obs_f = {f_ack0, f_ack1, f_v0, f_v1, f_d0, f_d1, f_ra};
    assign obs_r = {r_ack0, r_ack1, r_v0, r_v1, r_d0, r_d1, r_ra};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Two independent synchronous ROMs, one per arbiter.
    always_ff @(posedge clk) begin
        f_rd <= rom_mem[f_ra];
        r_rd <= rom_mem[r_ra];
    end

    // Expected outputs this cycle: {ack0, ack1, valid0, valid1, data0, data1, rom_addr}.
    function automatic logic [27:0] exp_vec(input int k);
        logic       a0, a1, p1, v0, v1;
        logic [7:0] ra, d0, d1;
        a0 = 1'b0;
        a1 = 1'b0;
        if (k == 0) p1 = (m_wait[0] == MAX_WAIT);
        else        p1 = (m_lastg[1] == 0);
        if (rst_n) begin
            if (req0 && req1) begin
                a0 = !p1;
                a1 = p1;
            end else begin
                a0 = req0;
                a1 = req1;
            end
        end
        ra = a0 ? addr0 : (a1 ? addr1 : m_laddr[k]);
        v0 = rst_n && (m_own[k] == 0);
        v1 = rst_n && (m_own[k] == 1);
        d0 = v0 ? (m_oaddr[k] ^ 8'hA5) : 8'h00;
        d1 = v1 ? (m_oaddr[k] ^ 8'hA5) : 8'h00;
        return {a0, a1, v0, v1, d0, d1, ra};
    endfunction

    task automatic model_reset(input int k);
        m_wait[k]  = 0;
        m_lastg[k] = 1;
        m_laddr[k] = 8'h00;
        m_own[k]   = -1;
        m_oaddr[k] = 8'h00;
    endtask

    task automatic advance(input int k);
        logic [27:0] e;
        e = exp_vec(k);
        if (!rst_n) begin
            model_reset(k);
        end else begin
            m_laddr[k] = e[7:0];
            m_oaddr[k] = e[7:0];
            if (e[27]) begin
                m_own[k] = 0;
                m_lastg[k] = 0;
            end else if (e[26]) begin
                m_own[k] = 1;
                m_lastg[k] = 1;
            end else begin
                m_own[k] = -1;
            end
            if (k == 0 && req1 && !e[26])
                m_wait[k] = (m_wait[k] < MAX_WAIT) ? m_wait[k] + 1 : MAX_WAIT;
            else
                m_wait[k] = 0;
        end
    endtask

    task automatic step(input logic r, input logic q0, input logic [7:0] a0,
                        input logic q1, input logic [7:0] a1);
        @(posedge clk);
        #1;
        rst_n = r;
        req0  = q0;
        addr0 = a0;
        req1  = q1;
        addr1 = a1;
        @(negedge clk);
        ef = exp_vec(0);
        er = exp_vec(1);
        advance(0);
        advance(1);
        cyc++;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 8'h55, 1'b1, 8'h66);
            checks++;
            if (obs_f !== ef) begin
                errors++;
                $display("FAIL reset fixed cyc %0d: got %h want %h", cyc, obs_f, ef);
            end
            checks++;
            if (obs_r !== er) begin
                errors++;
                $display("FAIL reset rr cyc %0d: got %h want %h", cyc, obs_r, er);
            end
            checks++;
            if ({f_ack0, f_ack1, f_v0, f_v1, r_ack0, r_ack1, r_v0, r_v1, f_ra} !== 16'h0) begin
                errors++;
                $display("FAIL reset_quiet cyc %0d: got acks/valids %b rom_addr %h want 0",
                         cyc, {f_ack0, f_ack1, f_v0, f_v1, r_ack0, r_ack1, r_v0, r_v1}, f_ra);
            end
        end
        step(1'b1, 1'b1, 8'h55, 1'b1, 8'h66);
        checks++;
        if ({f_ack0, f_ack1, r_ack0, r_ack1} !== 4'b1010) begin
            errors++;
            $display("FAIL first_tie cyc %0d: got %b want 1010",
                     cyc, {f_ack0, f_ack1, r_ack0, r_ack1});
        end
    endtask

    task automatic test_single();
        logic [7:0] want [3];
        want[0] = 8'hB5;
        want[1] = 8'hB4;
        want[2] = 8'hB7;
        for (int i = 0; i < 4; i++) begin
            if (i < 3) step(1'b1, 1'b1, 8'h10 + 8'(i), 1'b0, 8'h00);
            else       step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
            checks++;
            if (obs_f !== ef) begin
                errors++;
                $display("FAIL single fixed cyc %0d: got %h want %h", cyc, obs_f, ef);
            end
            checks++;
            if (obs_r !== er) begin
                errors++;
                $display("FAIL single rr cyc %0d: got %h want %h", cyc, obs_r, er);
            end
            if (i > 0) begin
                checks++;
                if (f_v0 !== 1'b1 || f_d0 !== want[i-1] || f_v1 !== 1'b0) begin
                    errors++;
                    $display("FAIL single_data cyc %0d: got v0=%b d0=%h v1=%b want 1 %h 0",
                             cyc, f_v0, f_d0, f_v1, want[i-1]);
                end
            end
        end
    endtask

    task automatic test_starve();
        for (int i = 0; i < 11; i++) begin
            if (i < 10) step(1'b1, 1'b1, 8'h40, 1'b1, 8'h41);
            else        step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
            checks++;
            if (obs_f !== ef) begin
                errors++;
                $display("FAIL starve fixed cyc %0d: got %h want %h", cyc, obs_f, ef);
            end
            checks++;
            if (obs_r !== er) begin
                errors++;
                $display("FAIL starve rr cyc %0d: got %h want %h", cyc, obs_r, er);
            end
            if (i < 10) begin
                checks++;
                if (f_ack1 !== (i % 5 == 4) || f_ack0 !== (i % 5 != 4)) begin
                    errors++;
                    $display("FAIL starve_ratio step %0d: got ack0=%b ack1=%b",
                             i, f_ack0, f_ack1);
                end
            end
        end
    endtask

    task automatic test_rr();
        logic prev;
        prev = 1'b0;
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 1'b1, 8'h20, 1'b1, 8'h30);
            checks++;
            if (obs_f !== ef) begin
                errors++;
                $display("FAIL rr fixed cyc %0d: got %h want %h", cyc, obs_f, ef);
            end
            checks++;
            if (obs_r !== er) begin
                errors++;
                $display("FAIL rr rr cyc %0d: got %h want %h", cyc, obs_r, er);
            end
            checks++;
            if ((r_v0 && r_v1) || (i > 0 && r_ack1 === prev)) begin
                errors++;
                $display("FAIL rr_alternate cyc %0d: got ack1=%b prev=%b v0=%b v1=%b",
                         cyc, r_ack1, prev, r_v0, r_v1);
            end
            prev = r_ack1;
        end
    endtask

    task automatic test_withdraw();
        for (int i = 0; i < 6; i++) begin
            case (i)
                1:       step(1'b1, 1'b1, 8'h50, 1'b1, 8'h51);
                2:       step(1'b1, 1'b1, 8'h52, 1'b0, 8'h51);
                default: step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
            endcase
            checks++;
            if (obs_f !== ef) begin
                errors++;
                $display("FAIL withdraw fixed cyc %0d: got %h want %h", cyc, obs_f, ef);
            end
            checks++;
            if (obs_r !== er) begin
                errors++;
                $display("FAIL withdraw rr cyc %0d: got %h want %h", cyc, obs_r, er);
            end
            if (i > 0) begin
                checks++;
                if (f_ack1 !== 1'b0 || f_v1 !== 1'b0) begin
                    errors++;
                    $display("FAIL withdraw_port1 cyc %0d: got ack1=%b v1=%b want 0 0",
                             cyc, f_ack1, f_v1);
                end
            end
            if (i > 2) begin
                checks++;
                if (f_ra !== 8'h52) begin
                    errors++;
                    $display("FAIL idle_hold cyc %0d: got rom_addr %h want 52", cyc, f_ra);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 13; i++) begin
            case (i)
                0:       step(1'b1, 1'b0, 8'h00, 1'b1, 8'h77);
                1:       step(1'b0, 1'b1, 8'h01, 1'b1, 8'h02);
                2:       step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
                6:       step(1'b0, 1'b1, 8'h03, 1'b1, 8'h04);
                default: step(1'b1, 1'b1, 8'h60 + 8'(i), 1'b1, 8'h70 + 8'(i));
            endcase
            checks++;
            if (obs_f !== ef) begin
                errors++;
                $display("FAIL reset_mid fixed cyc %0d: got %h want %h", cyc, obs_f, ef);
            end
            checks++;
            if (obs_r !== er) begin
                errors++;
                $display("FAIL reset_mid rr cyc %0d: got %h want %h", cyc, obs_r, er);
            end
            if (i == 1 || i == 2) begin
                checks++;
                if (f_v1 !== 1'b0 || r_v1 !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_drop cyc %0d: got v1 fixed=%b rr=%b want 0",
                             cyc, f_v1, r_v1);
                end
            end
            if (i >= 7 && i <= 11) begin
                checks++;
                if (f_ack1 !== (i == 11)) begin
                    errors++;
                    $display("FAIL reset_wait cyc %0d: got ack1=%b want %b",
                             cyc, f_ack1, (i == 11));
                end
            end
            if (i == 7) begin
                checks++;
                if (r_ack0 !== 1'b1) begin
                    errors++;
                    $display("FAIL reset_last_grant cyc %0d: got rr ack0=%b want 1",
                             cyc, r_ack0);
                end
            end
        end
    endtask

    task automatic test_random();
        logic r, q0, q1;
        logic [7:0] a0, a1;
        for (int i = 0; i < 400; i++) begin
            r  = ($urandom_range(0, 49) != 0);
            q0 = ($urandom_range(0, 3) != 0);
            q1 = ($urandom_range(0, 2) != 0);
            a0 = 8'($urandom);
            a1 = 8'($urandom);
            step(r, q0, a0, q1, a1);
            checks++;
            if (obs_f !== ef) begin
                errors++;
                $display("FAIL random fixed cyc %0d: got %h want %h", cyc, obs_f, ef);
            end
            checks++;
            if (obs_r !== er) begin
                errors++;
                $display("FAIL random rr cyc %0d: got %h want %h", cyc, obs_r, er);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        rst_n  = 1'b0;
        req0   = 1'b1;
        req1   = 1'b1;
        addr0  = 8'h00;
        addr1  = 8'h00;
        for (int i = 0; i < 256; i++) rom_mem[i] = 8'(i) ^ 8'hA5;
        model_reset(0);
        model_reset(1);
        test_reset();
        test_single();
        test_starve();
        test_rr();
        test_withdraw();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
